// File: rtl/logic_clk_div_pkg.sv
// Shared types and width helpers for the logic clock divider reconfiguration controller.
package logic_clk_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DRAIN,
    ST_LOAD,
    ST_SETTLE,
    ST_ACK
  } state_e;

  localparam int DEF_COUNTER_BITS  = 32;
  localparam int DEF_N_REQ         = 4;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_DRAIN_TIMEOUT = 1024;
  localparam int DEF_HALF          = 1;

  function automatic int owner_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int drain_cnt_w(int t);
    return $clog2(t) + 1;
  endfunction

  // Settle counter runs 0..s-1.
  function automatic int settle_cnt_w(int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/logic_clk_div_ctrl_if.sv
// Requester and divider-side signal bundle; slave = controller, master = requesters/divider.
interface logic_clk_div_ctrl_if
  import logic_clk_div_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int COUNTER_BITS = DEF_COUNTER_BITS
);
  localparam int OW = owner_w(N_REQ);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*COUNTER_BITS-1:0] req_half_period;
  logic [N_REQ-1:0]              req_ready;
  logic                          req_err;
  logic                          div_edge;
  logic                          div_load;
  logic [COUNTER_BITS-1:0]       div_half_period;
  logic                          div_enable;
  logic                          busy;
  logic [OW-1:0]                 cur_owner;
  logic                          drain_timeout;

  modport slave (
    input  req_valid, req_half_period, div_edge,
    output req_ready, req_err, div_load, div_half_period, div_enable,
           busy, cur_owner, drain_timeout
  );

  modport master (
    output req_valid, req_half_period, div_edge,
    input  req_ready, req_err, div_load, div_half_period, div_enable,
           busy, cur_owner, drain_timeout
  );
endinterface

// File: rtl/logic_clk_div_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module logic_clk_div_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  int j;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[IDX_W'(j)]) begin
        idx = IDX_W'(j);
        vld = 1'b1;
      end
    end
    if (!en) vld = 1'b0;
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/logic_clk_div_ctrl.sv
// Glitch-free reconfiguration sequencer for the logic clock divider:
// arbitrate, drain to a safe edge, gate, load, settle, re-enable, acknowledge.
module logic_clk_div_ctrl
  import logic_clk_div_pkg::*;
#(
  parameter int COUNTER_BITS  = DEF_COUNTER_BITS,
  parameter int N_REQ         = DEF_N_REQ,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int DEFAULT_HALF  = DEF_HALF
) (
  input logic            master_clk,
  input logic            master_rst,
  logic_clk_div_ctrl_if.slave bus
);

  localparam int OW = owner_w(N_REQ);
  localparam int DW = drain_cnt_w(DRAIN_TIMEOUT);
  localparam int SW = settle_cnt_w(SETTLE_CYCLES);

  state_e                  state_q, state_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [OW-1:0]           rr_q, rr_d;
  logic [COUNTER_BITS-1:0] hold_q, hold_d;
  logic [COUNTER_BITS-1:0] half_q, half_d;
  logic                    en_q, en_d;
  logic                    err_q, err_d;
  logic                    tmo_q, tmo_d;
  logic [DW-1:0]           dcnt_q, dcnt_d;
  logic [SW-1:0]           scnt_q, scnt_d;

  logic [N_REQ-1:0]        gnt;
  logic [OW-1:0]           gnt_idx;
  logic                    gnt_vld;
  logic [COUNTER_BITS-1:0] req_sel;
  logic [N_REQ-1:0]        ready;

  logic_clk_div_rr_arb #(.N_REQ(N_REQ), .IDX_W(OW)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_q),
    .en  (state_q == ST_IDLE),
    .gnt (gnt),
    .idx (gnt_idx),
    .vld (gnt_vld)
  );

  always_comb begin
    req_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) req_sel = req_sel | bus.req_half_period[i*COUNTER_BITS +: COUNTER_BITS];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    half_d  = half_q;
    en_d    = en_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    dcnt_d  = dcnt_q;
    scnt_d  = scnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          hold_d  = req_sel;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        err_d = (hold_q == '0);
        if (hold_q == '0) begin
          state_d = ST_ACK;
        end else if (!en_q) begin
          half_d  = hold_q;
          state_d = ST_LOAD;
        end else begin
          dcnt_d  = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // An edge coinciding with the timeout wins, so the flag stays clear.
        if (bus.div_edge) begin
          en_d    = 1'b0;
          half_d  = hold_q;
          state_d = ST_LOAD;
        end else if (dcnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
          en_d    = 1'b0;
          tmo_d   = 1'b1;
          half_d  = hold_q;
          state_d = ST_LOAD;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        scnt_d  = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
          en_d    = 1'b1;
          state_d = ST_ACK;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        rr_d    = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge master_clk or posedge master_rst) begin
    if (master_rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      half_q  <= COUNTER_BITS'(DEFAULT_HALF);
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      dcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      half_q  <= half_d;
      en_q    <= en_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == ST_ACK) ready[owner_q] = 1'b1;
  end

  // The new half-period is already presented during the load strobe cycle.
  assign bus.req_ready       = ready;
  assign bus.req_err         = (state_q == ST_ACK) && err_q;
  assign bus.div_load        = (state_q == ST_LOAD);
  assign bus.div_half_period = half_q;
  assign bus.div_enable      = en_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.cur_owner       = owner_q;
  assign bus.drain_timeout   = tmo_q;

endmodule

// File: tb/tb_logic_clk_div_ctrl.sv
// Self-checking bench for logic_clk_div_ctrl with a transaction-level reference model.
module tb_logic_clk_div_ctrl;
  localparam int N   = 4;
  localparam int CB  = 32;
  localparam int S   = 8;
  localparam int T   = 1024;
  localparam int DEF = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_clk_div_ctrl_if #(.N_REQ(N), .COUNTER_BITS(CB)) bus ();

  logic_clk_div_ctrl #(
    .COUNTER_BITS(CB), .N_REQ(N), .SETTLE_CYCLES(S),
    .DRAIN_TIMEOUT(T), .DEFAULT_HALF(DEF)
  ) dut (
    .master_clk (clk),
    .master_rst (rst),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the divider should look like after each completed request.
  int          m_ptr;
  logic        m_en;
  logic [CB-1:0] m_half;
  logic        m_tmo;

  // Observations of one transaction.
  int            o_ack, o_nload, o_load_cyc, o_fall;
  logic [N-1:0]  o_rdy;
  logic          o_err, o_busy1;
  logic [1:0]    o_own1;
  logic [CB-1:0] o_load_half;

  logic [CB-1:0] vals [N];

  function automatic int model_grant(logic [N-1:0] mask, int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_en = 1'b0; m_half = CB'(DEF); m_tmo = 1'b0;
  endtask

  // Cycle k is observed at the k-th falling edge after the request is driven.
  task automatic observe(input int edge_cyc, input int scr_cyc, input int bound);
    logic pen;
    o_ack = -1; o_nload = 0; o_load_cyc = -1; o_fall = -1;
    o_rdy = '0; o_err = 1'b0; o_own1 = '0; o_busy1 = 1'b0; o_load_half = '0;
    pen = bus.div_enable;
    for (int k = 0; k < bound; k++) begin
      bus.div_edge = (k == edge_cyc);
      if (k == scr_cyc)
        for (int i = 0; i < N; i++) bus.req_half_period[i*CB +: CB] = $urandom;
      if (k == 1) begin o_own1 = bus.cur_owner; o_busy1 = bus.busy; end
      if (bus.div_load) begin o_nload++; o_load_cyc = k; o_load_half = bus.div_half_period; end
      if (pen && !bus.div_enable && o_fall < 0) o_fall = k;
      pen = bus.div_enable;
      if (bus.req_ready != '0) begin
        o_ack = k; o_rdy = bus.req_ready; o_err = bus.req_err;
        break;
      end
      @(negedge clk);
    end
    bus.div_edge = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0; bus.req_half_period = '0; bus.div_edge = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.div_enable !== 1'b0) $display("FAIL rst_enable got %b exp 0", bus.div_enable); else n_pass++;
    n_checks++; if (bus.div_load !== 1'b0) $display("FAIL rst_load got %b exp 0", bus.div_load); else n_pass++;
    n_checks++; if (bus.div_half_period !== CB'(DEF)) $display("FAIL rst_half got %0d exp %0d", bus.div_half_period, DEF); else n_pass++;
    n_checks++; if (bus.req_ready !== '0 || bus.req_err !== 1'b0) $display("FAIL rst_ready got %b/%b exp 0/0", bus.req_ready, bus.req_err); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0 || bus.cur_owner !== '0) $display("FAIL rst_busy_owner got %b/%0d exp 0/0", bus.busy, bus.cur_owner); else n_pass++;
    n_checks++; if (bus.drain_timeout !== 1'b0) $display("FAIL rst_tmo got %b exp 0", bus.drain_timeout); else n_pass++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_disabled_load();
    bus.req_half_period[0 +: CB] = 32'd5;
    bus.req_valid = 4'b0001;
    observe(-1, -1, 40);
    n_checks++; if (o_load_cyc !== 2 || o_nload !== 1) $display("FAIL t1_load got cyc %0d n %0d exp cyc 2 n 1", o_load_cyc, o_nload); else n_pass++;
    n_checks++; if (o_load_half !== 32'd5) $display("FAIL t1_load_half got %0d exp 5", o_load_half); else n_pass++;
    n_checks++; if (o_ack !== 3 + S) $display("FAIL t1_ack_cyc got %0d exp %0d", o_ack, 3 + S); else n_pass++;
    n_checks++; if (o_rdy !== 4'b0001 || o_err !== 1'b0) $display("FAIL t1_ready got %b/%b exp 0001/0", o_rdy, o_err); else n_pass++;
    n_checks++; if (bus.div_enable !== 1'b1) $display("FAIL t1_enable got %b exp 1", bus.div_enable); else n_pass++;
    n_checks++; if (o_own1 !== 2'd0 || o_busy1 !== 1'b1) $display("FAIL t1_owner got %0d/%b exp 0/1", o_own1, o_busy1); else n_pass++;
    bus.req_valid = '0;
    m_half = 32'd5; m_en = 1'b1; m_ptr = 1;
    @(negedge clk);
  endtask

  task automatic test_drain_edge();
    int exp_ack;
    exp_ack = m_en ? 20 + 2 + S : 3 + S;
    bus.req_half_period[1*CB +: CB] = 32'd7;
    bus.req_valid = 4'b0010;
    observe(20, 5, 80);
    n_checks++; if (o_fall !== 21 || o_load_cyc !== 21) $display("FAIL t2_fall_load got %0d/%0d exp 21/21", o_fall, o_load_cyc); else n_pass++;
    n_checks++; if (o_ack !== exp_ack) $display("FAIL t2_ack_cyc got %0d exp %0d", o_ack, exp_ack); else n_pass++;
    n_checks++; if (o_rdy !== 4'b0010 || o_err !== 1'b0) $display("FAIL t2_ready got %b/%b exp 0010/0", o_rdy, o_err); else n_pass++;
    n_checks++; if (bus.div_half_period !== 32'd7) $display("FAIL t2_half got %0d exp 7", bus.div_half_period); else n_pass++;
    n_checks++; if (bus.drain_timeout !== 1'b0) $display("FAIL t2_tmo got %b exp 0", bus.drain_timeout); else n_pass++;
    bus.req_valid = '0;
    m_half = 32'd7; m_en = 1'b1; m_ptr = 2;
    @(negedge clk);
  endtask

  task automatic test_drain_timeout();
    logic [CB-1:0] v;
    v = $urandom | 32'h1;
    bus.req_half_period[3*CB +: CB] = v;
    bus.req_valid = 4'b1000;
    observe(-1, -1, T + 60);
    n_checks++; if (o_fall !== 2 + T) $display("FAIL t3_fall got %0d exp %0d", o_fall, 2 + T); else n_pass++;
    n_checks++; if (o_load_cyc !== 2 + T || o_load_half !== v) $display("FAIL t3_load got cyc %0d val %0h exp %0d/%0h", o_load_cyc, o_load_half, 2 + T, v); else n_pass++;
    n_checks++; if (o_ack !== 3 + T + S || o_rdy !== 4'b1000) $display("FAIL t3_ack got %0d/%b exp %0d/1000", o_ack, o_rdy, 3 + T + S); else n_pass++;
    n_checks++; if (bus.drain_timeout !== 1'b1) $display("FAIL t3_tmo got %b exp 1", bus.drain_timeout); else n_pass++;
    bus.req_valid = '0;
    m_half = v; m_en = 1'b1; m_tmo = 1'b1; m_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_reject();
    bus.req_half_period[2*CB +: CB] = '0;
    bus.req_valid = 4'b0100;
    observe(-1, -1, 20);
    n_checks++; if (o_ack !== 2 || o_rdy !== 4'b0100 || o_err !== 1'b1) $display("FAIL t4_ack got %0d/%b/%b exp 2/0100/1", o_ack, o_rdy, o_err); else n_pass++;
    n_checks++; if (o_nload !== 0) $display("FAIL t4_noload got %0d exp 0", o_nload); else n_pass++;
    n_checks++; if (bus.div_half_period !== m_half || bus.div_enable !== m_en) $display("FAIL t4_untouched got %0h/%b exp %0h/%b", bus.div_half_period, bus.div_enable, m_half, m_en); else n_pass++;
    n_checks++; if (bus.drain_timeout !== m_tmo) $display("FAIL t4_tmo_sticky got %b exp %b", bus.drain_timeout, m_tmo); else n_pass++;
    bus.req_valid = '0;
    m_ptr = 3;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_own, e, exp_ack;
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    for (int i = 0; i < N; i++) begin
      vals[i] = ($urandom & 32'hFFFF_FF00) | CB'(i + 1);
      bus.req_half_period[i*CB +: CB] = vals[i];
    end
    bus.req_valid = 4'b1111;
    for (int it = 0; it < 5; it++) begin
      exp_own = model_grant(4'b1111, m_ptr);
      e = $urandom_range(2, 25);
      exp_ack = m_en ? e + 2 + S : 3 + S;
      observe(e, -1, 80);
      n_checks++; if (o_rdy !== N'(1 << exp_own) || o_ack !== exp_ack) $display("FAIL t5_rr%0d got %b@%0d exp %b@%0d", it, o_rdy, o_ack, N'(1 << exp_own), exp_ack); else n_pass++;
      n_checks++; if (bus.div_half_period !== vals[exp_own]) $display("FAIL t5_half%0d got %0h exp %0h", it, bus.div_half_period, vals[exp_own]); else n_pass++;
      m_half = vals[exp_own]; m_en = 1'b1; m_ptr = (exp_own + 1) % N;
      if (it < 4) @(negedge clk);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_settle();
    logic [CB-1:0] v;
    int exp_load;
    v = $urandom | 32'h1;
    exp_load = m_en ? 4 : 2;
    bus.req_half_period[1*CB +: CB] = v;
    bus.req_valid = 4'b0010;
    observe(3, -1, 8);
    n_checks++; if (o_ack !== -1 || o_load_cyc !== exp_load || bus.busy !== 1'b1) $display("FAIL t6_pre got ack %0d load %0d busy %b exp -1/%0d/1", o_ack, o_load_cyc, bus.busy, exp_load); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.div_enable !== 1'b0 || bus.div_half_period !== CB'(DEF)) $display("FAIL t6_rst_div got %b/%0h exp 0/%0h", bus.div_enable, bus.div_half_period, DEF); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0 || bus.req_ready !== '0 || bus.cur_owner !== '0 || bus.div_load !== 1'b0) $display("FAIL t6_rst_state got %b/%b/%0d/%b exp 0/0/0/0", bus.busy, bus.req_ready, bus.cur_owner, bus.div_load); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== '0 || bus.drain_timeout !== 1'b0) $display("FAIL t6_rst_hold got %b/%b exp 0/0", bus.req_ready, bus.drain_timeout); else n_pass++;
    rst = 1'b0;
    model_reset();
    observe(-1, -1, 40);
    n_checks++; if (o_load_cyc !== 2 || o_load_half !== v) $display("FAIL t6_regrant_load got %0d/%0h exp 2/%0h", o_load_cyc, o_load_half, v); else n_pass++;
    n_checks++; if (o_ack !== 3 + S || o_rdy !== 4'b0010 || o_err !== 1'b0) $display("FAIL t6_regrant_ack got %0d/%b/%b exp %0d/0010/0", o_ack, o_rdy, o_err, 3 + S); else n_pass++;
    bus.req_valid = '0;
    m_half = v; m_en = 1'b1; m_ptr = 2;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0]  mask;
    logic [CB-1:0] v;
    int exp_own, e, exp_ack;
    for (int it = 0; it < 6; it++) begin
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        vals[i] = ($urandom_range(0, 3) == 0) ? '0 : CB'($urandom);
        bus.req_half_period[i*CB +: CB] = vals[i];
      end
      exp_own = model_grant(mask, m_ptr);
      v = vals[exp_own];
      e = $urandom_range(2, 25);
      exp_ack = (v == '0) ? 2 : (m_en ? e + 2 + S : 3 + S);
      bus.req_valid = mask;
      observe(e, 1, 80);
      n_checks++; if (o_rdy !== N'(1 << exp_own) || o_ack !== exp_ack || o_err !== (v == '0)) $display("FAIL rnd%0d_ack got %b@%0d err %b exp %b@%0d err %b", it, o_rdy, o_ack, o_err, N'(1 << exp_own), exp_ack, (v == '0)); else n_pass++;
      if (v != '0) begin m_half = v; m_en = 1'b1; end
      n_checks++; if (bus.div_half_period !== m_half || bus.div_enable !== m_en || o_nload !== ((v == '0) ? 0 : 1)) $display("FAIL rnd%0d_div got %0h/%b/%0d exp %0h/%b", it, bus.div_half_period, bus.div_enable, o_nload, m_half, m_en); else n_pass++;
      m_ptr = (exp_own + 1) % N;
      bus.req_valid = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_disabled_load();
    test_drain_edge();
    test_drain_timeout();
    test_reject();
    test_round_robin();
    test_reset_mid_settle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
